// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
//   Multicycle control unit for the ARM datapath: Moore main FSM, ALU decoder
//   and conditional-execution logic with an architectural NZCV register.
//
//   Optional feature macro: CMP_TST_EN
//     Defined   -> Cmd 1010 (CMP) and 1000 (TST) with S=1 update NZCV without
//                  writing a register.
//     Undefined -> those Cmds are treated as unsupported (Undef pulse).
//
//   Ports
//     clk         rising-edge clock
//     reset       synchronous, active-high
//     ToControler {Cond[3:0], Op[1:0], Funct[5:0]} from the IR
//     Rd          destination register from the IR
//     Flags       live ALU flags {N,Z,C,V}
//     PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//     ImmSrc, RegSrc, RegWrite, ALUControl   datapath control strobes
//     Undef       one-cycle pulse when an undefined instruction is dropped
module arm_multicycle_ctrl #(
    parameter int unsigned ALUW   = 4,
    parameter logic [3:0]  PC_REG = 4'd15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     ToControler,
    input  logic [3:0]      Rd,
    input  logic [3:0]      Flags,
    output logic            PCWrite,
    output logic            AdrSrc,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      ResultSrc,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ImmSrc,
    output logic [1:0]      RegSrc,
    output logic            RegWrite,
    output logic [ALUW-1:0] ALUControl,
    output logic            Undef
);

    localparam logic [ALUW-1:0] AluAdd = ALUW'(0);
    localparam logic [ALUW-1:0] AluSub = ALUW'(1);
    localparam logic [ALUW-1:0] AluAnd = ALUW'(2);
    localparam logic [ALUW-1:0] AluOrr = ALUW'(3);
    localparam logic [ALUW-1:0] AluEor = ALUW'(4);
    localparam logic [ALUW-1:0] AluMov = ALUW'(5);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
        StMemWr, StExecR, StExecI, StAluWb, StBranch
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      nzcv_q, nzcv_d;
    logic            cond_ex_q, cond_ex_d;

    logic [3:0]      cond;
    logic [1:0]      op;
    logic [3:0]      cmd;
    logic            imm_bit, s_bit;
    logic            rd_is_pc;
    logic            cond_met;
    logic [ALUW-1:0] alu_cmd;
    logic            cmd_valid;
    logic            no_write;

    assign cond     = ToControler[11:8];
    assign op       = ToControler[7:6];
    assign imm_bit  = ToControler[5];
    assign cmd      = ToControler[4:1];
    assign s_bit    = ToControler[0];  // also L for memory instructions
    assign rd_is_pc = (Rd == PC_REG);

    // Condition check against the stored NZCV only; live Flags never feed it.
    always_comb begin
        cond_met = 1'b0;
        case (cond)
            4'b0000: cond_met = nzcv_q[2];
            4'b0001: cond_met = ~nzcv_q[2];
            4'b0010: cond_met = nzcv_q[1];
            4'b0011: cond_met = ~nzcv_q[1];
            4'b0100: cond_met = nzcv_q[3];
            4'b0101: cond_met = ~nzcv_q[3];
            4'b0110: cond_met = nzcv_q[0];
            4'b0111: cond_met = ~nzcv_q[0];
            4'b1000: cond_met = nzcv_q[1] & ~nzcv_q[2];
            4'b1001: cond_met = ~nzcv_q[1] | nzcv_q[2];
            4'b1010: cond_met = (nzcv_q[3] == nzcv_q[0]);
            4'b1011: cond_met = (nzcv_q[3] != nzcv_q[0]);
            4'b1100: cond_met = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
            4'b1101: cond_met = nzcv_q[2] | (nzcv_q[3] != nzcv_q[0]);
            4'b1110: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    // ALU decoder
    always_comb begin
        alu_cmd   = AluAdd;
        cmd_valid = 1'b1;
        no_write  = 1'b0;
        case (cmd)
            4'b0100: alu_cmd = AluAdd;
            4'b0010: alu_cmd = AluSub;
            4'b0000: alu_cmd = AluAnd;
            4'b1100: alu_cmd = AluOrr;
            4'b0001: alu_cmd = AluEor;
            4'b1101: alu_cmd = AluMov;
`ifdef CMP_TST_EN
            4'b1010: begin
                alu_cmd   = AluSub;
                no_write  = 1'b1;
                cmd_valid = s_bit;
            end
            4'b1000: begin
                alu_cmd   = AluAnd;
                no_write  = 1'b1;
                cmd_valid = s_bit;
            end
`endif
            default: cmd_valid = 1'b0;
        endcase
        if (!cmd_valid) begin
            alu_cmd = AluAdd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            nzcv_q    <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nzcv_q    <= nzcv_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nzcv_d     = nzcv_q;
        cond_ex_d  = cond_ex_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        RegWrite   = 1'b0;
        ALUControl = AluAdd;
        Undef      = 1'b0;
        if (reset) begin
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    IRWrite   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    state_d   = StDecode;
                end
                StDecode: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    // Latch the verdict now so a flag write in EXEC cannot
                    // change it for the write-back of this same instruction.
                    cond_ex_d = cond_met;
                    if (cond == 4'b1111 || op == 2'b11) begin
                        Undef   = 1'b1;
                        state_d = StFetch;
                    end else if (op == 2'b01) begin
                        state_d = StMemAdr;
                    end else if (op == 2'b10) begin
                        state_d = StBranch;
                    end else begin
                        state_d = imm_bit ? StExecI : StExecR;
                    end
                end
                StMemAdr: begin
                    ALUSrcB = 2'b01;
                    ImmSrc  = 2'b01;
                    state_d = s_bit ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    AdrSrc  = 1'b1;
                    state_d = StMemWb;
                end
                StMemWb: begin
                    ResultSrc = 2'b01;
                    PCWrite   = cond_ex_q & rd_is_pc;
                    RegWrite  = cond_ex_q & ~rd_is_pc;
                    state_d   = StFetch;
                end
                StMemWr: begin
                    AdrSrc   = 1'b1;
                    MemWrite = cond_ex_q;
                    RegSrc   = 2'b10;
                    state_d  = StFetch;
                end
                StExecR, StExecI: begin
                    ALUSrcB    = (state_q == StExecI) ? 2'b01 : 2'b00;
                    ALUControl = alu_cmd;
                    Undef      = ~cmd_valid;
                    if (cmd_valid && s_bit && cond_ex_q) begin
                        nzcv_d = Flags;
                    end
                    state_d = StAluWb;
                end
                StAluWb: begin
                    PCWrite  = cond_ex_q & cmd_valid & ~no_write & rd_is_pc;
                    RegWrite = cond_ex_q & cmd_valid & ~no_write & ~rd_is_pc;
                    state_d  = StFetch;
                end
                StBranch: begin
                    RegSrc    = 2'b01;
                    ALUSrcB   = 2'b01;
                    ImmSrc    = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = cond_ex_q;
                    state_d   = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

endmodule
